i2c_txn_arbiter: RTL and testbench

- Shares one standard-mode I2C master among NUM_REQ requesters and sequences complete single-byte transactions on it.
- Round-robin arbitration between requesters.
- Programs the master's register bus (clock divider, slave address, TX byte, mode, start), polls its status, collects the RX byte and returns a one-cycle response to the winner.
- Sits between client blocks (sensor pollers, config loaders) and the I2C master register interface.

---
 rtl/i2c_txn_arbiter.sv | 258 +++++++++++++++++++++++++
 tb/tb_i2c_txn_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_txn_arbiter.sv
// rtl/i2c_txn_arbiter.sv - round-robin sharer of one I2C master running single-byte transactions
// Optional watchdog on the status polling: define I2C_ARB_TIMEOUT_EN.
module i2c_txn_arbiter #(
   parameter int          NUM_REQ     = 4,
   parameter logic [7:0]  CLK_DIV     = 8'd100,
   parameter int          POLL_GAP    = 16,
   parameter logic [19:0] TIMEOUT_CYC = 20'd200000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [NUM_REQ*7-1:0] req_addr,
   input  logic [NUM_REQ*8-1:0] req_wdata,
   input  logic [NUM_REQ-1:0]   req_rd,
   output logic [NUM_REQ-1:0]   gnt,
   output logic                 rsp_valid,
   output logic [2:0]           rsp_id,
   output logic [7:0]           rsp_rdata,
   output logic [1:0]           rsp_err,
   output logic                 busy,
   output logic                 m_wr,
   output logic [7:0]           m_addr_offset,
   output logic [31:0]          m_wdata,
   input  logic [31:0]          m_rdata
);
   typedef enum logic [3:0] {
      S_IDLE, S_CFG, S_START, S_GAP, S_POLL, S_PCHK, S_RDATA, S_RCHK, S_STOP, S_RESP
   } state_t;

   state_t             r_state, w_state_n;
   logic [7:0]         r_cnt, w_cnt_n;
   logic [2:0]         r_rr, w_rr_n;
   logic [2:0]         r_id, w_id_n;
   logic [6:0]         r_addr, w_addr_n;
   logic [7:0]         r_txb, w_txb_n;
   logic               r_rd, w_rd_n;
   logic               r_seen, w_seen_n;
   logic [7:0]         r_rxb, w_rxb_n;
   logic [1:0]         r_err, w_err_n;
   logic [NUM_REQ-1:0] r_gnt, w_gnt_n;
   logic               r_rsp_valid, w_rsp_valid_n;
   logic [2:0]         r_rsp_id, w_rsp_id_n;
   logic [7:0]         r_rsp_rdata, w_rsp_rdata_n;
   logic [1:0]         r_rsp_err, w_rsp_err_n;
   logic               r_busy, w_busy_n;
   logic               r_m_wr, w_m_wr_n;
   logic [7:0]         r_m_off, w_m_off_n;
   logic [31:0]        r_m_wdata, w_m_wdata_n;
   logic               w_found;
   logic [2:0]         w_sel;
   logic [7:0]         w_req8;
`ifdef I2C_ARB_TIMEOUT_EN
   logic [19:0]        r_tmo, w_tmo_n;
`endif

   assign w_req8 = 8'(req);

   // Scan downwards so the requester closest to the pointer is the last (winning) hit.
   always_comb begin
      w_found = 1'b0;
      w_sel   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         int idx;
         idx = int'(r_rr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (w_req8[3'(idx)]) begin
            w_found = 1'b1;
            w_sel   = 3'(idx);
         end
      end
   end

   always_comb begin
      w_state_n = r_state;
      w_cnt_n   = r_cnt;
      w_rr_n    = r_rr;
      w_id_n    = r_id;
      w_addr_n  = r_addr;
      w_txb_n   = r_txb;
      w_rd_n    = r_rd;
      w_seen_n  = r_seen;
      w_rxb_n   = r_rxb;
      w_err_n   = r_err;
      w_gnt_n   = '0;
`ifdef I2C_ARB_TIMEOUT_EN
      w_tmo_n   = r_tmo;
`endif
      case (r_state)
         S_IDLE: begin
            if (w_found) begin
               w_state_n = S_CFG;
               w_cnt_n   = '0;
               w_id_n    = w_sel;
               w_rr_n    = (int'(w_sel) == NUM_REQ - 1) ? 3'd0 : w_sel + 3'd1;
               w_err_n   = 2'b00;
               w_rxb_n   = '0;
               for (int i = 0; i < NUM_REQ; i++) begin
                  if (w_sel == 3'(i)) begin
                     w_gnt_n[i] = 1'b1;
                     w_addr_n   = req_addr[7*i +: 7];
                     w_txb_n    = req_wdata[8*i +: 8];
                     w_rd_n     = req_rd[i];
                  end
               end
            end
         end
         S_CFG: begin
            if (r_cnt == 8'd3) w_state_n = S_START;
            else               w_cnt_n   = r_cnt + 8'd1;
         end
         S_START: begin
            w_seen_n  = 1'b0;
            w_cnt_n   = '0;
            w_state_n = S_GAP;
         end
         S_GAP: begin
            if (r_cnt == 8'(POLL_GAP - 1)) w_state_n = S_POLL;
            else                           w_cnt_n   = r_cnt + 8'd1;
         end
         S_POLL: w_state_n = S_PCHK;
         // A done flag before any active flag belongs to the previous transaction.
         S_PCHK: begin
            w_cnt_n = '0;
            case (m_rdata[1:0])
               2'b10: begin
                  w_seen_n  = 1'b1;
                  w_state_n = S_GAP;
               end
               2'b11: begin
                  w_err_n   = 2'b01;
                  w_state_n = S_STOP;
               end
               2'b01: begin
                  if (r_seen) w_state_n = r_rd ? S_RDATA : S_STOP;
                  else        w_state_n = S_GAP;
               end
               default: w_state_n = S_GAP;
            endcase
         end
         S_RDATA: w_state_n = S_RCHK;
         S_RCHK: begin
            w_rxb_n   = m_rdata[7:0];
            w_state_n = S_STOP;
         end
         S_STOP:  w_state_n = S_RESP;
         S_RESP:  w_state_n = S_IDLE;
         default: w_state_n = S_IDLE;
      endcase
`ifdef I2C_ARB_TIMEOUT_EN
      if (r_state == S_START) w_tmo_n = '0;
      if (r_state inside {S_GAP, S_POLL, S_PCHK, S_RDATA, S_RCHK}) begin
         w_tmo_n = r_tmo + 20'd1;
         if (r_tmo >= TIMEOUT_CYC - 20'd1) begin
            w_state_n = S_STOP;
            w_err_n   = 2'b10;
            w_rxb_n   = '0;
         end
      end
`endif
      // Outputs are registered, so decode them from the state being entered.
      w_rsp_valid_n = 1'b0;
      w_rsp_id_n    = '0;
      w_rsp_rdata_n = '0;
      w_rsp_err_n   = '0;
      w_m_wr_n      = 1'b0;
      w_m_off_n     = 8'h14;
      w_m_wdata_n   = '0;
      w_busy_n      = (w_state_n != S_IDLE) && (w_state_n != S_RESP);
      case (w_state_n)
         S_CFG: begin
            w_m_wr_n = 1'b1;
            case (w_cnt_n[1:0])
               2'd0: begin w_m_off_n = 8'h04; w_m_wdata_n = {24'd0, CLK_DIV};  end
               2'd1: begin w_m_off_n = 8'h08; w_m_wdata_n = {25'd0, w_addr_n}; end
               2'd2: begin w_m_off_n = 8'h0C; w_m_wdata_n = {24'd0, w_txb_n};  end
               default: begin w_m_off_n = 8'h18; w_m_wdata_n = {31'd0, w_rd_n}; end
            endcase
         end
         S_START: begin
            w_m_wr_n    = 1'b1;
            w_m_off_n   = 8'h00;
            w_m_wdata_n = 32'd1;
         end
         S_STOP: begin
            w_m_wr_n  = 1'b1;
            w_m_off_n = 8'h00;
         end
         S_RDATA: w_m_off_n = 8'h10;
         S_RESP: begin
            w_rsp_valid_n = 1'b1;
            w_rsp_id_n    = w_id_n;
            w_rsp_rdata_n = w_rxb_n;
            w_rsp_err_n   = w_err_n;
         end
         default: w_m_off_n = 8'h14;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_rr        <= '0;
         r_id        <= '0;
         r_addr      <= '0;
         r_txb       <= '0;
         r_rd        <= 1'b0;
         r_seen      <= 1'b0;
         r_rxb       <= '0;
         r_err       <= '0;
         r_gnt       <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_id    <= '0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= '0;
         r_busy      <= 1'b0;
         r_m_wr      <= 1'b0;
         r_m_off     <= 8'h14;
         r_m_wdata   <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
         r_tmo       <= '0;
`endif
      end else begin
         r_state     <= w_state_n;
         r_cnt       <= w_cnt_n;
         r_rr        <= w_rr_n;
         r_id        <= w_id_n;
         r_addr      <= w_addr_n;
         r_txb       <= w_txb_n;
         r_rd        <= w_rd_n;
         r_seen      <= w_seen_n;
         r_rxb       <= w_rxb_n;
         r_err       <= w_err_n;
         r_gnt       <= w_gnt_n;
         r_rsp_valid <= w_rsp_valid_n;
         r_rsp_id    <= w_rsp_id_n;
         r_rsp_rdata <= w_rsp_rdata_n;
         r_rsp_err   <= w_rsp_err_n;
         r_busy      <= w_busy_n;
         r_m_wr      <= w_m_wr_n;
         r_m_off     <= w_m_off_n;
         r_m_wdata   <= w_m_wdata_n;
`ifdef I2C_ARB_TIMEOUT_EN
         r_tmo       <= w_tmo_n;
`endif
      end
   end

   assign gnt           = r_gnt;
   assign rsp_valid     = r_rsp_valid;
   assign rsp_id        = r_rsp_id;
   assign rsp_rdata     = r_rsp_rdata;
   assign rsp_err       = r_rsp_err;
   assign busy          = r_busy;
   assign m_wr          = r_m_wr;
   assign m_addr_offset = r_m_off;
   assign m_wdata       = r_m_wdata;
endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// tb/tb_i2c_txn_arbiter.sv - randomized bench for i2c_txn_arbiter with a time-scripted I2C master model
module tb_i2c_txn_arbiter;
   localparam int N   = 4;
   localparam int GAP = 16;
   localparam int TMO = 1000;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   req = '0;
   logic [N*7-1:0] req_addr = '0;
   logic [N*8-1:0] req_wdata = '0;
   logic [N-1:0]   req_rd = '0;
   logic [N-1:0]   gnt;
   logic           rsp_valid;
   logic [2:0]     rsp_id;
   logic [7:0]     rsp_rdata;
   logic [1:0]     rsp_err;
   logic           busy;
   logic           m_wr;
   logic [7:0]     m_addr_offset;
   logic [31:0]    m_wdata;
   logic [31:0]    m_rdata;

   always #5 clk = ~clk;

   i2c_txn_arbiter #(
      .NUM_REQ(N), .CLK_DIV(8'd100), .POLL_GAP(GAP), .TIMEOUT_CYC(20'(TMO))
   ) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_rd(req_rd), .gnt(gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy), .m_wr(m_wr),
      .m_addr_offset(m_addr_offset), .m_wdata(m_wdata), .m_rdata(m_rdata)
   );

   int n_chk = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Master model: status follows a script timed from the START write (stale, busy, final).
   int         sc_s, sc_b;
   logic [1:0] sc_fin;
   logic [7:0] sc_rx;
   int         ms_t, ms_s, ms_b;
   logic       ms_run;
   logic [1:0] ms_prev, ms_fin, ms_status;
   logic [7:0] ms_rx;

   always_comb begin
      if (!ms_run)                 ms_status = 2'b00;
      else if (ms_t < ms_s)        ms_status = (ms_prev == 2'b01) ? 2'b01 : 2'b00;
      else if (ms_t < ms_s + ms_b) ms_status = 2'b10;
      else                         ms_status = ms_fin;
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ms_run <= 1'b0; ms_t <= 0; ms_s <= 0; ms_b <= 0;
         ms_prev <= 2'b00; ms_fin <= 2'b00; ms_rx <= 8'd0; m_rdata <= 32'd0;
      end else begin
         if (m_addr_offset == 8'h14)      m_rdata <= {30'd0, ms_status};
         else if (m_addr_offset == 8'h10) m_rdata <= {24'd0, ms_rx};
         else                             m_rdata <= 32'd0;
         if (m_wr && m_addr_offset == 8'h00 && m_wdata[0]) begin
            ms_run <= 1'b1; ms_t <= 0; ms_prev <= ms_status;
            ms_s <= sc_s; ms_b <= sc_b; ms_fin <= sc_fin; ms_rx <= sc_rx;
         end else if (ms_run) begin
            ms_t <= ms_t + 1;
         end
      end
   end

   // Bus monitor: write log, RX-register reads, response count, grant overlap.
   int          cyc = 0;
   int          start_cyc = 0;
   int          rsp_total = 0;
   int          rd10 = 0;
   int          last_delta = 0;
   logic        outstanding = 1'b0;
   logic [39:0] wr_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst_n) begin
         if (m_wr) begin
            wr_q.push_back({m_addr_offset, m_wdata});
            if (m_addr_offset == 8'h00 && m_wdata == 32'd1) start_cyc = cyc;
         end
         if (!m_wr && m_addr_offset == 8'h10) rd10++;
         if (|gnt) begin
            check("gnt_while_busy", {39'd0, outstanding}, 40'd0);
            outstanding = 1'b1;
         end
         if (rsp_valid) begin
            outstanding = 1'b0;
            rsp_total++;
         end
      end
   end

   logic [6:0] a_addr[N];
   logic [7:0] a_wdata[N];
   bit         a_rd[N];
   int         rr = 0;
   int         n_txn = 0;

   task automatic randomize_reqs();
      for (int i = 0; i < N; i++) begin
         a_addr[i]  = 7'($urandom);
         a_wdata[i] = 8'($urandom);
         a_rd[i]    = 1'($urandom);
      end
   endtask

   task automatic drive_fields();
      for (int i = 0; i < N; i++) begin
         req_addr[7*i +: 7]  = a_addr[i];
         req_wdata[8*i +: 8] = a_wdata[i];
         req_rd[i]           = a_rd[i];
      end
   endtask

   task automatic check_idle_outputs();
      check("idle_gnt", 40'(gnt), 40'd0);
      check("idle_rsp_valid", 40'(rsp_valid), 40'd0);
      check("idle_rsp_id", 40'(rsp_id), 40'd0);
      check("idle_rsp_rdata", 40'(rsp_rdata), 40'd0);
      check("idle_rsp_err", 40'(rsp_err), 40'd0);
      check("idle_busy", 40'(busy), 40'd0);
      check("idle_m_wr", 40'(m_wr), 40'd0);
      check("idle_m_off", 40'(m_addr_offset), 40'h14);
      check("idle_m_wdata", 40'(m_wdata), 40'd0);
   endtask

   // One transaction: predicted winner, write sequence, response fields.
   task automatic do_txn(input logic [N-1:0] mask, input bit keep, input int s, input int b,
                         input logic [1:0] fin, input logic [7:0] rx);
      int          win;
      int          w;
      bit          rd_ok;
      logic [39:0] exp_q[$];
      logic [N-1:0] one;
      win = -1;
      for (int k = 0; k < N; k++) begin
         int idx;
         idx = (rr + k) % N;
         if (win < 0 && mask[idx]) win = idx;
      end
      sc_s = s; sc_b = b; sc_fin = fin; sc_rx = rx;
      wr_q.delete();
      rd10 = 0;
      drive_fields();
      req = mask;
      w = 0;
      do begin @(negedge clk); w++; end while (gnt == '0 && w < 50);
      one = 1;
      check("gnt_onehot", 40'(gnt), 40'(one << win));
      check("busy_at_gnt", 40'(busy), 40'd1);
      if (!keep) req = '0;
      rr = (win + 1) % N;
      if (gnt == '0) return;
      n_txn++;
      w = 0;
      do begin @(negedge clk); w++; end while (!rsp_valid && w < 5000);
      check("rsp_seen", 40'(rsp_valid), 40'd1);
      last_delta = cyc - start_cyc;
      rd_ok = (fin == 2'b01) && a_rd[win];
      check("rsp_id", 40'(rsp_id), 40'(win));
      check("rsp_err", 40'(rsp_err), (fin == 2'b11) ? 40'd1 : (fin == 2'b00) ? 40'd2 : 40'd0);
      check("rsp_rdata", 40'(rsp_rdata), rd_ok ? 40'(rx) : 40'd0);
      check("busy_at_rsp", 40'(busy), 40'd0);
      check("rx_reg_reads", 40'(rd10), rd_ok ? 40'd1 : 40'd0);
      exp_q.push_back({8'h04, 32'd100});
      exp_q.push_back({8'h08, 25'd0, a_addr[win]});
      exp_q.push_back({8'h0C, 24'd0, a_wdata[win]});
      exp_q.push_back({8'h18, 31'd0, a_rd[win]});
      exp_q.push_back({8'h00, 32'd1});
      exp_q.push_back({8'h00, 32'd0});
      check("wr_count", 40'(wr_q.size()), 40'd6);
      for (int i = 0; i < 6 && i < wr_q.size(); i++) check("wr_seq", wr_q[i], exp_q[i]);
   endtask

   initial begin
      int w;
      logic [1:0] fin;
      int s, b;
      repeat (3) @(negedge clk);
      check_idle_outputs();
      rst_n = 1'b1;
      @(negedge clk);

      // Round robin with every request held.
      for (int i = 0; i < 5; i++) begin
         randomize_reqs();
         do_txn(4'b1111, i < 4, 0, 24, 2'b01, 8'($urandom));
      end

      randomize_reqs();
      a_addr[0] = 7'h50; a_wdata[0] = 8'hA5; a_rd[0] = 1'b0;
      do_txn(4'b0001, 1'b0, 0, 20, 2'b01, 8'h00);

      randomize_reqs();
      a_rd[2] = 1'b1;
      do_txn(4'b0100, 1'b0, 0, 20, 2'b01, 8'h3C);

      // Previous done flag still visible after START.
      randomize_reqs();
      a_rd[1] = 1'b1;
      do_txn(4'b0010, 1'b0, 40, 25, 2'b01, 8'h5A);

      randomize_reqs();
      a_rd[3] = 1'b1;
      do_txn(4'b1000, 1'b0, 0, 0, 2'b11, 8'h77);

      for (int r = 0; r < 30; r++) begin
         randomize_reqs();
         fin = ($urandom_range(0, 3) == 0) ? 2'b11 : 2'b01;
         s = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 40));
         b = (fin == 2'b11 && $urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(20, 60));
         do_txn(4'($urandom_range(1, 15)), 1'b0, s, b, fin, 8'($urandom));
      end

`ifdef I2C_ARB_TIMEOUT_EN
      randomize_reqs();
      do_txn(4'b0001, 1'b0, 0, 0, 2'b00, 8'h99);
      check("tmo_window", 40'(last_delta >= TMO - GAP - 2 && last_delta <= TMO + GAP + 4), 40'd1);
`endif

      repeat (4) @(negedge clk);
      check("rsp_total", 40'(rsp_total), 40'(n_txn));

      // Reset in the middle of the configuration writes.
      randomize_reqs();
      drive_fields();
      req = 4'b0010;
      w = 0;
      do begin @(negedge clk); w++; end while (!(m_wr && m_addr_offset == 8'h08) && w < 60);
      check("cfg_reached", 40'(m_addr_offset), 40'h08);
      req = '0;
      #2 rst_n = 1'b0;
      #1 check_idle_outputs();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
